// File: rtl/serial_cmp_encoder.sv
// serial_cmp_encoder: streams the MSB-first bitwise comparison of two captured
// words as 2-bit (y, z) symbols, stopping after the first mismatching bit.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet, result holds last verdict
// S_SEND | driving the symbol for bit idx, held for HOLD cycles
// S_DONE | one-cycle done pulse; result carries the final symbol
//
// Symbol / result code: 01 equal, 10 A bit > B bit, 11 B bit > A bit, 00 none.
module serial_cmp_encoder #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y,
  output logic             z,
  output logic             sym_valid,
  output logic             sym_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [1:0]       yz_q, yz_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       result_q, result_d;

  logic [IW-1:0]    idx_next;
  logic [1:0]       sym_new;

  function automatic logic [1:0] sym_of(input logic abit, input logic bbit);
    if (abit == bbit) return 2'b01;
    else if (abit)    return 2'b10;
    else              return 2'b11;
  endfunction

  // Next-state and next-output computation; outputs are registered so the
  // symbol for a bit is computed one edge ahead of when it appears.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    yz_d     = yz_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    idx_next = idx_q - IW'(1);
    sym_new  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The MSB symbol comes straight from the inputs so that it is on
          // the wire right after the accepting edge.
          sym_new  = sym_of(a[WIDTH-1], b[WIDTH-1]);
          a_d      = a;
          b_d      = b;
          idx_d    = IDX_MSB;
          hold_d   = HOLD_TOP;
          yz_d     = sym_new;
          valid_d  = 1'b1;
          last_d   = (sym_new != 2'b01) || (WIDTH == 1);
          busy_d   = 1'b1;
          result_d = 2'b00;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if ((yz_q != 2'b01) || (idx_q == '0)) begin
          // Exit is decided before idx would go below zero.
          yz_d     = 2'b00;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          done_d   = 1'b1;
          result_d = yz_q;
          state_d  = S_DONE;
        end else begin
          sym_new = sym_of(a_q[idx_next], b_q[idx_next]);
          idx_d   = idx_next;
          hold_d  = HOLD_TOP;
          yz_d    = sym_new;
          last_d  = (sym_new != 2'b01) || (idx_next == '0);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        yz_d    = 2'b00;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset overrides start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      yz_q     <= 2'b00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      yz_q     <= yz_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign y         = yz_q[1];
  assign z         = yz_q[0];
  assign sym_valid = valid_q;
  assign sym_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_serial_cmp_encoder.sv
// Bench for serial_cmp_encoder: three instances (3x1, 3x2, 1x1) driven by
// directed and random comparisons against a list-of-symbols reference model.
module tb_serial_cmp_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, start2;
  logic [2:0] a0, b0, a1, b1;
  logic [0:0] a2, b2;

  // Packed view of each instance: {y, z, sym_valid, sym_last, busy, done, result}
  wire [7:0] o0, o1, o2;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_syms[$];

  serial_cmp_encoder #(.WIDTH(3), .HOLD(1)) u_w3h1 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .y(o0[7]), .z(o0[6]), .sym_valid(o0[5]), .sym_last(o0[4]),
    .busy(o0[3]), .done(o0[2]), .result(o0[1:0]));

  serial_cmp_encoder #(.WIDTH(3), .HOLD(2)) u_w3h2 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .y(o1[7]), .z(o1[6]), .sym_valid(o1[5]), .sym_last(o1[4]),
    .busy(o1[3]), .done(o1[2]), .result(o1[1:0]));

  serial_cmp_encoder #(.WIDTH(1), .HOLD(1)) u_w1h1 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .y(o2[7]), .z(o2[6]), .sym_valid(o2[5]), .sym_last(o2[4]),
    .busy(o2[3]), .done(o2[2]), .result(o2[1:0]));

  function automatic logic [7:0] outs(input int inst);
    case (inst)
      0:       return o0;
      1:       return o1;
      default: return o2;
    endcase
  endfunction

  task automatic set_in(input int inst, input logic st, input logic [2:0] av, input logic [2:0] bv);
    case (inst)
      0:       begin start0 = st; a0 = av; b0 = bv; end
      1:       begin start1 = st; a1 = av; b1 = bv; end
      default: begin start2 = st; a2 = av[0]; b2 = bv[0]; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v, input logic [7:0] mask);
    checks++;
    assert ((obs & mask) === (exp_v & mask)) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs & mask, exp_v & mask);
    end
  endtask

  // Reference: walk bits MSB-first, emit one symbol per bit, stop at first mismatch.
  task automatic build_model(input int w, input logic [2:0] av, input logic [2:0] bv);
    exp_syms.delete();
    for (int i = w - 1; i >= 0; i--) begin
      logic [1:0] s;
      if (av[i] == bv[i])     s = 2'b01;
      else if (av[i] > bv[i]) s = 2'b10;
      else                    s = 2'b11;
      exp_syms.push_back(s);
      if (s != 2'b01) break;
    end
  endtask

  // Called at a negedge. Requests a comparison and checks every cycle through
  // the first idle cycle. perturb: during SEND keep start high and scramble a/b.
  // keep_start: leave start high at the end so the next edge re-accepts.
  task automatic run_cmp(input int inst, input logic [2:0] av, input logic [2:0] bv,
                         input bit keep_start, input bit perturb);
    int w, h, n;
    logic [1:0] fin;
    w = (inst == 2) ? 1 : 3;
    h = (inst == 1) ? 2 : 1;
    build_model(w, av, bv);
    n   = exp_syms.size();
    fin = exp_syms[n-1];
    set_in(inst, 1'b1, av, bv);
    @(negedge clk);
    set_in(inst, 1'b0, av, bv);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < h; c++) begin
        chk($sformatf("send%0d_k%0d_c%0d", inst, k, c), outs(inst),
            {exp_syms[k], 1'b1, (k == n - 1), 1'b1, 1'b0, 2'b00}, 8'hFC);
        if (perturb) set_in(inst, 1'b1, 3'($urandom), 3'($urandom));
        @(negedge clk);
      end
    end
    chk($sformatf("done%0d", inst), outs(inst), {6'b000011, fin}, 8'hFF);
    if (perturb) set_in(inst, keep_start, 3'($urandom), 3'($urandom));
    else         set_in(inst, keep_start, av, bv);
    @(negedge clk);
    chk($sformatf("idle%0d", inst), outs(inst), {6'b000000, fin}, 8'hFF);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 3'b000, 3'b000);
    set_in(1, 1'b0, 3'b000, 3'b000);
    set_in(2, 1'b0, 3'b000, 3'b000);
    repeat (3) @(negedge clk);
    chk("reset0", o0, 8'h00, 8'hFF);
    chk("reset1", o1, 8'h00, 8'hFF);
    chk("reset2", o2, 8'h00, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the plan
    run_cmp(0, 3'b111, 3'b101, 0, 0);
    run_cmp(0, 3'b010, 3'b110, 0, 0);
    run_cmp(1, 3'b101, 3'b101, 0, 0);
    run_cmp(2, 3'b001, 3'b000, 0, 0);
    run_cmp(2, 3'b000, 3'b000, 0, 0);

    // Robustness: start re-pulsed and a/b scrambled during SEND, start held
    // across DONE so the following comparison is accepted without a gap.
    run_cmp(0, 3'b000, 3'b111, 1, 1);
    run_cmp(0, 3'b110, 3'b100, 1, 0);
    run_cmp(1, 3'b011, 3'b011, 0, 1);
    set_in(0, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    chk("quiet0", o0, {6'b000000, 2'b10}, 8'hFF);

    // Reset during the second symbol of a=b=111
    set_in(0, 1'b1, 3'b111, 3'b111);
    @(negedge clk);
    set_in(0, 1'b0, 3'b111, 3'b111);
    chk("abort_sym0", o0, {2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00}, 8'hFC);
    @(negedge clk);
    chk("abort_sym1", o0, {2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00}, 8'hFC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_clear", o0, 8'h00, 8'hFF);
    @(negedge clk);
    chk("abort_nodone", o0, 8'h00, 8'hFF);

    // rst and start on the same edge: rst wins
    rst = 1'b1;
    set_in(0, 1'b1, 3'b100, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1'b0, 3'b100, 3'b000);
    chk("rst_start_a", o0, 8'h00, 8'hFF);
    @(negedge clk);
    chk("rst_start_b", o0, 8'h00, 8'hFF);
    run_cmp(0, 3'b111, 3'b111, 0, 0);

    // Random comparisons; b is a sparse flip of a so long equal prefixes occur
    for (int i = 0; i < 15; i++) begin
      for (int inst = 0; inst < 3; inst++) begin
        logic [2:0] av, bv;
        av = 3'($urandom);
        bv = av ^ (3'($urandom) & 3'($urandom));
        run_cmp(inst, av, bv, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
